shared_addsub_arbiter: RTL and testbench

- Shares one 32-bit add/subtract datapath between NUM_REQ requesters, e.g. neuron units doing membrane-potential updates inside a neuromorphic core.
- A round-robin arbiter grants one requester at a time and latches its operands.
- Results are returned with the winning requester's ID. Each granted operation takes three cycles.

---
 rtl/shared_addsub_arbiter.sv | 129 ++++++++++++
 tb/tb_shared_addsub_arbiter.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/shared_addsub_arbiter.sv
// One 32-bit add/subtract datapath shared by NUM_REQ requesters.
// Requesters are granted round-robin. Each granted operation runs IDLE -> EXEC -> RESP.
module shared_addsub_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 32,
  parameter int ID_W    = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        op_add,
  input  logic [NUM_REQ*DATA_W-1:0] a_flat,
  input  logic [NUM_REQ*DATA_W-1:0] b_flat,
  output logic [NUM_REQ-1:0]        ack,
  output logic [DATA_W-1:0]         result,
  output logic [ID_W-1:0]           result_id,
  output logic                      result_valid,
  output logic                      overflow,
  output logic                      busy
);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

  state_t              r_state;
  logic [ID_W-1:0]     r_last_grant;
  logic [ID_W-1:0]     r_id;
  logic [DATA_W-1:0]   r_a;
  logic [DATA_W-1:0]   r_b;
  logic                r_op_add;
  logic [NUM_REQ-1:0]  r_ack;
  logic [DATA_W-1:0]   r_result;
  logic [ID_W-1:0]     r_result_id;
  logic                r_result_valid;
  logic                r_overflow;

  logic [DATA_W-1:0]   w_a_lane [NUM_REQ];
  logic [DATA_W-1:0]   w_b_lane [NUM_REQ];
  logic [ID_W:0]       w_cand_sum [NUM_REQ];
  logic [ID_W-1:0]     w_cand_id [NUM_REQ];
  logic [NUM_REQ-1:0]  w_cand_req;
  logic [ID_W-1:0]     w_pick;
  logic [DATA_W-1:0]   w_res;
  logic                w_ovf;

  // Candidate gi is the requester at offset gi+1 from the last grant, wrapped.
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_lane
      assign w_a_lane[gi]   = a_flat[gi*DATA_W +: DATA_W];
      assign w_b_lane[gi]   = b_flat[gi*DATA_W +: DATA_W];
      assign w_cand_sum[gi] = {1'b0, r_last_grant} + (ID_W+1)'(gi + 1);
      assign w_cand_id[gi]  = (w_cand_sum[gi] >= (ID_W+1)'(NUM_REQ))
                              ? ID_W'(w_cand_sum[gi] - (ID_W+1)'(NUM_REQ))
                              : w_cand_sum[gi][ID_W-1:0];
      assign w_cand_req[gi] = req[w_cand_id[gi]];
    end
  endgenerate

  // Lowest offset wins, so scan from the far end and let nearer hits override.
  always_comb begin
    w_pick = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (w_cand_req[k]) begin
        w_pick = w_cand_id[k];
      end
    end
  end

  always_comb begin
    w_res = r_op_add ? (r_a + r_b) : (r_a - r_b);
    if (r_op_add) begin
      w_ovf = (r_a[DATA_W-1] == r_b[DATA_W-1]) && (w_res[DATA_W-1] != r_a[DATA_W-1]);
    end else begin
      w_ovf = (r_a[DATA_W-1] != r_b[DATA_W-1]) && (w_res[DATA_W-1] != r_a[DATA_W-1]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_last_grant   <= ID_W'(NUM_REQ - 1);
      r_id           <= '0;
      r_a            <= '0;
      r_b            <= '0;
      r_op_add       <= 1'b0;
      r_ack          <= '0;
      r_result       <= '0;
      r_result_id    <= '0;
      r_result_valid <= 1'b0;
      r_overflow     <= 1'b0;
    end else begin
      r_ack          <= '0;
      r_result_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (|req) begin
            r_id         <= w_pick;
            r_last_grant <= w_pick;
            r_a          <= w_a_lane[w_pick];
            r_b          <= w_b_lane[w_pick];
            r_op_add     <= op_add[w_pick];
            r_ack        <= NUM_REQ'(1) << w_pick;
            r_state      <= S_EXEC;
          end
        end
        S_EXEC: begin
          r_result       <= w_res;
          r_result_id    <= r_id;
          r_overflow     <= w_ovf;
          r_result_valid <= 1'b1;
          r_state        <= S_RESP;
        end
        S_RESP: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign ack          = r_ack;
  assign result       = r_result;
  assign result_id    = r_result_id;
  assign result_valid = r_result_valid;
  assign overflow     = r_overflow;
  assign busy         = (r_state != S_IDLE);

endmodule

// File: tb/tb_shared_addsub_arbiter.sv
// Directed bench for shared_addsub_arbiter: reset, add/sub overflow, round-robin order,
// wrap-around, reset abort and back-to-back reuse.
module tb_shared_addsub_arbiter;
  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 32;
  localparam int ID_W    = 2;

  logic                      clk;
  logic                      reset;
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ-1:0]        op_add;
  logic [NUM_REQ*DATA_W-1:0] a_flat;
  logic [NUM_REQ*DATA_W-1:0] b_flat;
  logic [NUM_REQ-1:0]        ack;
  logic [DATA_W-1:0]         result;
  logic [ID_W-1:0]           result_id;
  logic                      result_valid;
  logic                      overflow;
  logic                      busy;

  int checks   = 0;
  int failures = 0;

  shared_addsub_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .ID_W(ID_W)) dut (
    .clk(clk), .reset(reset), .req(req), .op_add(op_add),
    .a_flat(a_flat), .b_flat(b_flat), .ack(ack), .result(result),
    .result_id(result_id), .result_valid(result_valid),
    .overflow(overflow), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lane(input int i, input logic add, input logic [31:0] a, input logic [31:0] b);
    op_add[i]          = add;
    a_flat[i*32 +: 32] = a;
    b_flat[i*32 +: 32] = b;
  endtask

  // Advances until ack is seen; n is the number of edges consumed.
  task automatic wait_ack(output bit ok, output int n);
    ok = 1'b0;
    n  = 0;
    for (int t = 0; t < 12; t++) begin
      tick();
      n++;
      if (ack != '0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; req = '0; op_add = '0; a_flat = '0; b_flat = '0;
    tick(); tick();
    checks++; if (ack !== 4'b0000) begin failures++; $display("FAIL reset_ack got=%b exp=0000", ack); end
    checks++; if (result !== 32'h0) begin failures++; $display("FAIL reset_result got=%h exp=00000000", result); end
    checks++; if (result_id !== 2'd0) begin failures++; $display("FAIL reset_id got=%0d exp=0", result_id); end
    checks++; if ({result_valid, overflow, busy} !== 3'b000) begin failures++; $display("FAIL reset_flags got=%b exp=000", {result_valid, overflow, busy}); end
    reset = 1'b0;
    tick();
    $display("test_reset done");
  endtask

  task automatic test_basic_sub();
    bit ok; int n;
    set_lane(0, 1'b0, 32'd100, 32'd200);
    req = 4'b0001;
    wait_ack(ok, n);
    checks++; if (!ok) begin failures++; $display("FAIL basic_ack_timeout got=none exp=ack"); end
    checks++; if (n !== 1) begin failures++; $display("FAIL basic_latency got=%0d exp=1", n); end
    checks++; if (ack !== 4'b0001 || busy !== 1'b1) begin failures++; $display("FAIL basic_ack got=%b busy=%b exp=0001 busy=1", ack, busy); end
    req = '0;
    tick();
    checks++; if (result_valid !== 1'b1 || ack !== 4'b0000) begin failures++; $display("FAIL basic_valid got=%b ack=%b exp=1 ack=0000", result_valid, ack); end
    checks++; if (result !== 32'hFFFFFF9C || result_id !== 2'd0 || overflow !== 1'b0) begin failures++; $display("FAIL basic_result got=%h id=%0d ov=%b exp=ffffff9c id=0 ov=0", result, result_id, overflow); end
    tick();
    checks++; if (result_valid !== 1'b0 || busy !== 1'b0 || result !== 32'hFFFFFF9C) begin failures++; $display("FAIL basic_hold got=v%b busy%b %h exp=v0 busy0 ffffff9c", result_valid, busy, result); end
    $display("test_basic_sub result=%h id=%0d ov=%b", result, result_id, overflow);
  endtask

  task automatic test_add_overflow();
    bit ok; int n;
    set_lane(2, 1'b1, 32'h7FFFFFFF, 32'h1);
    req = 4'b0100;
    wait_ack(ok, n);
    checks++; if (!ok || ack !== 4'b0100) begin failures++; $display("FAIL addov_ack got=%b exp=0100", ack); end
    req = '0;
    tick();
    checks++; if (result_valid !== 1'b1 || result !== 32'h80000000 || result_id !== 2'd2 || overflow !== 1'b1) begin
      failures++; $display("FAIL addov_result got=v%b %h id=%0d ov=%b exp=v1 80000000 id=2 ov=1", result_valid, result, result_id, overflow);
    end
    tick();
    $display("test_add_overflow result=%h id=%0d ov=%b", result, result_id, overflow);
  endtask

  task automatic test_round_robin();
    bit ok; int n;
    int exp_order [5] = '{0, 1, 2, 3, 0};
    reset = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) set_lane(i, 1'b1, 32'(i * 16), 32'd3);
    req = 4'b1111;
    tick(); tick();
    reset = 1'b0;
    for (int g = 0; g < 5; g++) begin
      wait_ack(ok, n);
      checks++; if (!ok || ack !== (4'b0001 << exp_order[g])) begin failures++; $display("FAIL rr_grant%0d got=%b exp=%b", g, ack, 4'b0001 << exp_order[g]); end
      checks++; if (n !== ((g == 0) ? 1 : 2)) begin failures++; $display("FAIL rr_spacing%0d got=%0d exp=%0d", g, n, (g == 0) ? 1 : 2); end
      if (g == 4) req = '0;
      tick();
      checks++; if (result_valid !== 1'b1 || result_id !== 2'(exp_order[g]) || result !== 32'(exp_order[g] * 16 + 3)) begin
        failures++; $display("FAIL rr_result%0d got=v%b id=%0d %0d exp=v1 id=%0d %0d", g, result_valid, result_id, result, exp_order[g], exp_order[g] * 16 + 3);
      end
      $display("test_round_robin grant=%0d id=%0d result=%0d", g, result_id, result);
    end
    tick();
  endtask

  task automatic test_wrap();
    bit ok; int n;
    set_lane(2, 1'b0, 32'd10, 32'd3);
    req = 4'b0100;
    wait_ack(ok, n);
    req = '0;
    tick();
    checks++; if (!ok || result !== 32'd7 || result_id !== 2'd2) begin failures++; $display("FAIL wrap_setup got=%0d id=%0d exp=7 id=2", result, result_id); end
    tick();
    set_lane(0, 1'b1, 32'd1, 32'd1);
    set_lane(2, 1'b1, 32'd20, 32'd22);
    req = 4'b0101;
    wait_ack(ok, n);
    checks++; if (!ok || ack !== 4'b0001) begin failures++; $display("FAIL wrap_first got=%b exp=0001", ack); end
    req[0] = 1'b0;
    tick();
    checks++; if (result !== 32'd2 || result_id !== 2'd0) begin failures++; $display("FAIL wrap_first_res got=%0d id=%0d exp=2 id=0", result, result_id); end
    wait_ack(ok, n);
    checks++; if (!ok || ack !== 4'b0100) begin failures++; $display("FAIL wrap_second got=%b exp=0100", ack); end
    req = '0;
    tick();
    checks++; if (result !== 32'd42 || result_id !== 2'd2) begin failures++; $display("FAIL wrap_second_res got=%0d id=%0d exp=42 id=2", result, result_id); end
    tick();
    $display("test_wrap last result=%0d id=%0d", result, result_id);
  endtask

  task automatic test_reset_mid_op();
    bit ok; int n;
    set_lane(1, 1'b1, 32'd7, 32'd8);
    req = 4'b0010;
    wait_ack(ok, n);
    checks++; if (!ok || ack !== 4'b0010) begin failures++; $display("FAIL abort_ack got=%b exp=0010", ack); end
    reset = 1'b1;
    req   = '0;
    tick();
    checks++; if (result_valid !== 1'b0 || ack !== 4'b0000 || busy !== 1'b0) begin failures++; $display("FAIL abort_flags got=v%b ack=%b busy=%b exp=v0 ack=0000 busy=0", result_valid, ack, busy); end
    checks++; if (result !== 32'h0 || result_id !== 2'd0 || overflow !== 1'b0) begin failures++; $display("FAIL abort_outputs got=%h id=%0d ov=%b exp=00000000 id=0 ov=0", result, result_id, overflow); end
    reset = 1'b0;
    set_lane(0, 1'b1, 32'd9, 32'd9);
    req = 4'b0111;
    wait_ack(ok, n);
    checks++; if (!ok || ack !== 4'b0001) begin failures++; $display("FAIL abort_next_grant got=%b exp=0001", ack); end
    req = '0;
    tick();
    checks++; if (result_valid !== 1'b1 || result !== 32'd18 || result_id !== 2'd0) begin failures++; $display("FAIL abort_next_res got=v%b %0d id=%0d exp=v1 18 id=0", result_valid, result, result_id); end
    tick();
    $display("test_reset_mid_op result=%0d id=%0d", result, result_id);
  endtask

  task automatic test_back_to_back();
    bit ok; int n;
    set_lane(1, 1'b0, 32'h80000000, 32'h1);
    req = 4'b0010;
    wait_ack(ok, n);
    checks++; if (!ok || ack !== 4'b0010) begin failures++; $display("FAIL b2b_ack1 got=%b exp=0010", ack); end
    set_lane(1, 1'b0, 32'd5, 32'd5);
    tick();
    checks++; if (result_valid !== 1'b1 || result !== 32'h7FFFFFFF || overflow !== 1'b1 || result_id !== 2'd1) begin
      failures++; $display("FAIL b2b_res1 got=v%b %h ov=%b id=%0d exp=v1 7fffffff ov=1 id=1", result_valid, result, overflow, result_id);
    end
    tick();
    checks++; if (result_valid !== 1'b0 || result !== 32'h7FFFFFFF) begin failures++; $display("FAIL b2b_hold got=v%b %h exp=v0 7fffffff", result_valid, result); end
    tick();
    checks++; if (ack !== 4'b0010) begin failures++; $display("FAIL b2b_ack2 got=%b exp=0010", ack); end
    req = '0;
    tick();
    checks++; if (result_valid !== 1'b1 || result !== 32'h0 || overflow !== 1'b0) begin failures++; $display("FAIL b2b_res2 got=v%b %h ov=%b exp=v1 00000000 ov=0", result_valid, result, overflow); end
    tick();
    $display("test_back_to_back result=%h ov=%b", result, overflow);
  endtask

  initial begin
    test_reset();
    test_basic_sub();
    test_add_overflow();
    test_round_robin();
    test_wrap();
    test_reset_mid_op();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
